// File: rtl/lcd_bus_master.sv
// 8080-style parallel LCD bus master: valid/ready beats become timed CS/WR/RD/RS strobes.
// Read beats are built only when LCD_READ_EN is defined; otherwise every beat is a write.
module lcd_bus_master #(
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned T_SETUP    = 1,
  parameter int unsigned T_PULSE    = 2,
  parameter int unsigned T_HOLD     = 1,
  parameter int unsigned T_RST      = 4,
  parameter int unsigned T_RST_WAIT = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic              s_rs,
  input  logic              s_rd,
  input  logic              s_last,
  input  logic [DATA_W-1:0] s_data,
  input  logic              panel_rst_req,
  output logic              r_valid,
  output logic [DATA_W-1:0] r_data,
  output logic              done,
  output logic              busy,
  output logic              lcd_cs_n,
  output logic              lcd_wr_n,
  output logic              lcd_rd_n,
  output logic              lcd_rs,
  output logic              lcd_rst_n,
  output logic [DATA_W-1:0] lcd_d_o,
  input  logic [DATA_W-1:0] lcd_d_i,
  output logic              lcd_d_oe
);

  localparam int unsigned Max1 = (T_SETUP > T_PULSE) ? T_SETUP : T_PULSE;
  localparam int unsigned Max2 = (Max1 > T_HOLD) ? Max1 : T_HOLD;
  localparam int unsigned Max3 = (Max2 > T_RST) ? Max2 : T_RST;
  localparam int unsigned MaxT = (Max3 > T_RST_WAIT) ? Max3 : T_RST_WAIT;
  localparam int unsigned CntW = $clog2(MaxT + 1);

  localparam logic [CntW-1:0] LdSetup = CntW'(T_SETUP - 1);
  localparam logic [CntW-1:0] LdPulse = CntW'(T_PULSE - 1);
  localparam logic [CntW-1:0] LdHold  = CntW'(T_HOLD - 1);
  localparam logic [CntW-1:0] LdRst   = CntW'(T_RST - 1);
  localparam logic [CntW-1:0] LdWait  = CntW'(T_RST_WAIT - 1);

  typedef enum logic [2:0] {
    StIdle, StSetup, StStrobe, StHold, StBurst, StRstLo, StRstWt
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            rst_pend_q, rst_pend_d;
  logic            rd_q, last_q;
  logic            accept, enter_rstlo, beat_end;
  logic            s_rd_eff, beat_rd, in_beat_d, strobe_last;

`ifdef LCD_READ_EN
  assign s_rd_eff = s_rd;
`else
  assign s_rd_eff = 1'b0;
  logic unused_rd_inputs;
  assign unused_rd_inputs = ^{s_rd, lcd_d_i};
`endif

  assign s_ready     = ((state_q == StIdle) || (state_q == StBurst)) && !rst_pend_q;
  assign busy        = (state_q != StIdle);
  assign accept      = s_valid && s_ready;
  assign strobe_last = (state_q == StStrobe) && (cnt_q == '0);

  always_comb begin
    state_d     = state_q;
    cnt_d       = (cnt_q != '0) ? cnt_q - CntW'(1) : cnt_q;
    enter_rstlo = 1'b0;
    beat_end    = 1'b0;
    unique case (state_q)
      StIdle, StBurst: begin
        // A pending panel reset wins over a waiting command.
        if (rst_pend_q) begin
          state_d     = StRstLo;
          cnt_d       = LdRst;
          enter_rstlo = 1'b1;
        end else if (s_valid) begin
          state_d = StSetup;
          cnt_d   = LdSetup;
        end
      end
      StSetup: if (cnt_q == '0) begin
        state_d = StStrobe;
        cnt_d   = LdPulse;
      end
      StStrobe: if (cnt_q == '0) begin
        state_d = StHold;
        cnt_d   = LdHold;
      end
      StHold: if (cnt_q == '0) begin
        beat_end = 1'b1;
        state_d  = last_q ? StIdle : StBurst;
      end
      StRstLo: if (cnt_q == '0) begin
        state_d = StRstWt;
        cnt_d   = LdWait;
      end
      StRstWt: if (cnt_q == '0) begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign rst_pend_d = panel_rst_req || (rst_pend_q && !enter_rstlo);
  // Pins are registered from the next state so they line up with state_q.
  assign beat_rd    = accept ? s_rd_eff : rd_q;
  assign in_beat_d  = (state_d == StSetup) || (state_d == StStrobe) || (state_d == StHold);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      rst_pend_q <= 1'b0;
      rd_q       <= 1'b0;
      last_q     <= 1'b0;
      lcd_cs_n   <= 1'b1;
      lcd_wr_n   <= 1'b1;
      lcd_rs     <= 1'b0;
      lcd_rst_n  <= 1'b1;
      lcd_d_o    <= '0;
      lcd_d_oe   <= 1'b0;
      done       <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rst_pend_q <= rst_pend_d;
      lcd_cs_n   <= !(in_beat_d || (state_d == StBurst));
      lcd_wr_n   <= !((state_d == StStrobe) && !beat_rd);
      lcd_rst_n  <= (state_d != StRstLo);
      lcd_d_oe   <= in_beat_d && !beat_rd;
      done       <= beat_end;
      if (accept) begin
        rd_q    <= s_rd_eff;
        last_q  <= s_last;
        lcd_rs  <= s_rs;
        lcd_d_o <= s_data;
      end
    end
  end

`ifdef LCD_READ_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      lcd_rd_n <= 1'b1;
      r_valid  <= 1'b0;
      r_data   <= '0;
    end else begin
      lcd_rd_n <= !((state_d == StStrobe) && beat_rd);
      r_valid  <= beat_end && rd_q;
      if (strobe_last && rd_q) begin
        r_data <= lcd_d_i;
      end
    end
  end
`else
  logic unused_strobe_last;
  assign unused_strobe_last = strobe_last;
  assign lcd_rd_n = 1'b1;
  assign r_valid  = 1'b0;
  assign r_data   = '0;
`endif

endmodule

// File: doc/lcd_bus_master.md
Name: lcd_bus_master

Overview:
- Parametrised 8080-style parallel LCD bus master.
- Converts a valid/ready command stream into timed CS/WR/RD/RS strobes with programmable setup, strobe and hold cycle counts.
- Supports burst transfers with CS held low, read-back cycles, and a sequenced panel hardware-reset pulse.
- Sits between the AXI-Stream-facing calculator/display logic and the LCD pins.

Parameters:
- DATA_W, 16, width of LCD data bus (8, 9, 16 or 18).
- T_SETUP, 1, cycles CS/RS/data valid before strobe falls (>=1).
- T_PULSE, 2, cycles WR_n/RD_n held low (>=1).
- T_HOLD, 1, cycles after strobe rises before CS may rise or next beat starts (>=1).
- T_RST, 4, cycles lcd_rst_n held low during panel reset (>=1).
- T_RST_WAIT, 3, cycles after lcd_rst_n rises before new commands are accepted (>=1).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- s_valid  in  1  command valid
- s_ready  out  1  command accepted when s_valid&&s_ready at posedge
- s_rs  in  1  register select for beat (0=command, 1=data)
- s_rd  in  1  1=read beat, 0=write beat
- s_last  in  1  1=release CS after this beat; 0=keep CS low (burst)
- s_data  in  DATA_W  write data
- panel_rst_req  in  1  one-cycle request for a panel hardware reset
- r_valid  out  1  one-cycle pulse, r_data valid
- r_data  out  DATA_W  captured read data
- done  out  1  one-cycle pulse at end of every beat
- busy  out  1  high in any state other than IDLE
- lcd_cs_n, lcd_wr_n, lcd_rd_n, lcd_rs, lcd_rst_n  out  1  panel control pins
- lcd_d_o  out  DATA_W  data to pad
- lcd_d_i  in  DATA_W  data from pad
- lcd_d_oe  out  1  pad output enable

Behaviour:
- One clock (clk); synchronous active-high reset (rst).
- All outputs are registered except s_ready and busy, which decode the current state.
- Reset values: lcd_cs_n=1, lcd_wr_n=1, lcd_rd_n=1, lcd_rs=0, lcd_rst_n=1, lcd_d_o=0, lcd_d_oe=0, r_valid=0, r_data=0, done=0. State becomes IDLE and the pending reset flag clears.
- rst mid-beat aborts immediately; the pins return to reset values next cycle.
- States:
  - IDLE: cs_n=1. s_ready=!rst_pend.
  - SETUP: cs_n=0; rs and data driven; strobes high.
  - STROBE: wr_n=0 for write, rd_n=0 for read.
  - HOLD: strobes high; cs_n=0.
  - BURST: cs_n=0; s_ready=!rst_pend.
  - RSTLO: lcd_rst_n=0, cs_n=1.
  - RSTWT: lcd_rst_n=1, waiting out T_RST_WAIT.
- Accept (IDLE or BURST, s_valid&&s_ready): latch rs/rd/last/data, go to SETUP. Pins change on the following cycle.
- Data bus: lcd_d_oe=1 from SETUP through HOLD of a write beat; 0 during read beats and in IDLE.
- Dwell times: SETUP lasts T_SETUP cycles, STROBE lasts T_PULSE, HOLD lasts T_HOLD. One shared down-counter of width clog2(max param + 1) times every dwell.
- Read capture: lcd_d_i is sampled into r_data on the edge that ends the last STROBE cycle.
- End of HOLD: done=1 for one cycle (the cycle after HOLD). For a read beat, r_valid=1 in the same cycle. Next state is IDLE if last=1, else BURST.
- Beat period (SETUP through HOLD) is T_SETUP+T_PULSE+T_HOLD cycles. A new accept in BURST starts the next SETUP with no CS glitch.
- BURST persists indefinitely with cs_n=0 until the next accept or a panel reset.
- panel_rst_req sets rst_pend in any state.
  - rst_pend is serviced only from IDLE or BURST, with priority over s_valid (s_ready=0 while pending).
  - From BURST, cs_n rises in the same transition into RSTLO.
  - Sequence: RSTLO for T_RST cycles, then RSTWT for T_RST_WAIT cycles, then IDLE; rst_pend clears on entry to RSTLO.
  - panel_rst_req during RSTLO/RSTWT sets rst_pend again, so one further reset follows.
- s_valid asserted in any other state is ignored until s_ready=1 (no loss; the source holds it).

Optional Feature:
- Macro: LCD_READ_EN.
- Defined: read beats as described.
- Undefined: s_rd is ignored and every beat is a write; lcd_rd_n is tied to 1; r_valid stays 0; r_data stays 0; lcd_d_i is unused.

Test Plan:
- Single write, defaults (T=1/2/1), s_rs=1, s_data=16'hA5C3, s_last=1 -> cs_n low 4 cycles; wr_n low exactly cycles 2-3 of those; lcd_d_o=A5C3 with d_oe=1 throughout; done pulse once; cs_n high afterwards.
- Burst of 3 writes (0x0011, 0x0022, 0x0033), last only on 3rd, s_valid back-to-back -> cs_n stays low continuously; 3 wr_n pulses; 3 done pulses; cs_n rises after 3rd HOLD.
- Read with LCD_READ_EN, lcd_d_i=16'h1234 during STROBE -> rd_n low 2 cycles; d_oe=0; r_valid+done pulse with r_data=1234; wr_n stays 1.
- panel_rst_req pulsed mid-write-beat -> beat completes; then lcd_rst_n low 4 cycles and high 3 more cycles with s_ready=0; then s_ready=1.
- rst asserted during STROBE -> next cycle all pins at reset values, busy=0; a fresh write then completes normally.
- Build without LCD_READ_EN, s_rd=1, s_data=16'h00FF -> executes as write (wr_n pulses, d_oe=1); r_valid never asserted.
